// File: rtl/lcd_host_seq.sv
// Host-side sequencer for an LCD controller: queues host commands in a small FIFO,
// issues them one at a time and streams a 64-pixel frame from image memory on a load.
module lcd_host_seq #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] cmd_in,
  input  logic       cmd_in_valid,
  output logic       cmd_in_ready,
  output logic       img_rd,
  output logic [5:0] img_addr,
  input  logic [7:0] img_data,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic [7:0] datain,
  input  logic       busy,
  output logic       done
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [2:0] CmdLoad = 3'd1;

  typedef enum logic [1:0] {StIdle, StIssue, StLoad, StWait} state_e;

  state_e          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [2:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, empty, push, pop;
  logic [2:0]      head;

  // Readiness comes from the registered count only, so a pop never frees space in its own cycle.
  assign full         = (count_q == CntW'(FIFO_DEPTH));
  assign empty        = (count_q == '0);
  assign cmd_in_ready = !full;
  assign push         = cmd_in_valid && cmd_in_ready;
  assign pop          = (state_q == StIssue);
  assign head         = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= cmd_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
    end
  end

  // cnt_q counts LOAD cycles (1..64) and, reused, WAIT cycles (1..3, saturating).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    cmd       = cmd_q;
    cmd_valid = 1'b0;
    img_rd    = 1'b0;
    img_addr  = '0;
    datain    = '0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty && !busy) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        cmd_valid = 1'b1;
        cmd       = head;
        cmd_d     = head;
        cnt_d     = 7'd1;
        if (head == CmdLoad) begin
          img_rd  = 1'b1;
          state_d = StLoad;
        end else begin
          state_d = StWait;
        end
      end
      StLoad: begin
        datain = img_data;
        if (cnt_q < 7'd64) begin
          img_rd   = 1'b1;
          img_addr = cnt_q[5:0];
          cnt_d    = cnt_q + 7'd1;
        end else begin
          state_d = StWait;
          cnt_d   = 7'd1;
        end
      end
      StWait: begin
        if (cnt_q >= 7'd3) begin
          if (!busy) begin
            done    = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_lcd_host_seq.sv
// Directed self-checking bench for lcd_host_seq with a simple image memory model
// returning addr*3 one cycle after each read strobe.
module tb_lcd_host_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] cmd_in;
  logic       cmd_in_valid;
  logic       cmd_in_ready;
  logic       img_rd;
  logic [5:0] img_addr;
  logic [7:0] img_data = 8'h00;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  lcd_host_seq #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_in       (cmd_in),
    .cmd_in_valid (cmd_in_valid),
    .cmd_in_ready (cmd_in_ready),
    .img_rd       (img_rd),
    .img_addr     (img_addr),
    .img_data     (img_data),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .datain       (datain),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (img_rd) img_data <= 8'(img_addr * 3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!seen) begin
        if (cmd_valid) seen = 1'b1;
        else tick();
      end
    end
    if (!seen && cmd_valid) seen = 1'b1;
  endtask

  task automatic push_one(input logic [2:0] c);
    cmd_in       = c;
    cmd_in_valid = 1'b1;
    tick();
    cmd_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_in = 3'd0; cmd_in_valid = 1'b0; busy = 1'b0;
    #2;
    checks++;
    if ({cmd_in_ready, cmd_valid, cmd, datain, img_rd, img_addr, done} !==
        {1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b cv=%b cmd=%0d din=%0d rd=%b addr=%0d done=%b",
               cmd_in_ready, cmd_valid, cmd, datain, img_rd, img_addr, done);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || cmd_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cmd_valid=%b ready=%b, want 0 1", cmd_valid, cmd_in_ready);
    end
  endtask

  task automatic test_load();
    bit seen;
    int bad_k;
    busy = 1'b0;
    push_one(3'd1);
    wait_issue(4, seen);
    checks++;
    if (!seen || cmd !== 3'd1 || img_rd !== 1'b1 || img_addr !== 6'd0) begin
      errors++;
      $display("FAIL load_issue: seen=%b cmd=%0d rd=%b addr=%0d, want 1 1 1 0",
               seen, cmd, img_rd, img_addr);
    end
    bad_k = -1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      checks++;
      if (datain !== 8'(3 * (k - 1)) || img_rd !== (k < 64) ||
          img_addr !== ((k < 64) ? 6'(k) : 6'd0) || cmd_valid !== 1'b0) begin
        errors++;
        if (bad_k < 0) begin
          bad_k = k;
          $display("FAIL load_stream k=%0d: din=%0d rd=%b addr=%0d cv=%b, want din=%0d",
                   k, datain, img_rd, img_addr, cmd_valid, 3 * (k - 1));
        end
      end
    end
    for (int w = 1; w <= 3; w++) begin
      tick();
      checks++;
      if (done !== (w == 3) || datain !== 8'd0 || img_rd !== 1'b0) begin
        errors++;
        $display("FAIL load_wait w=%0d: done=%b din=%0d rd=%b, want done=%b din=0 rd=0",
                 w, done, datain, img_rd, w == 3);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || cmd !== 3'd1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_after: done=%b cmd=%0d cv=%b, want 0 1 0", done, cmd, cmd_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_q [4];
    bit seen;
    int quiet;
    exp_q[0] = 3'd2; exp_q[1] = 3'd4; exp_q[2] = 3'd4; exp_q[3] = 3'd0;
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmd_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready push %0d: ready=%b, want 1", i, cmd_in_ready);
      end
      push_one(exp_q[i]);
    end
    // FIFO now full: a push of 7 must be refused while busy blocks issue
    cmd_in = 3'd7; cmd_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_in_ready !== 1'b0 || cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL full_refuse cyc %0d: ready=%b cv=%b, want 0 0", i, cmd_in_ready, cmd_valid);
      end
      tick();
    end
    cmd_in_valid = 1'b0;
    busy = 1'b0;
    for (int n = 0; n < 4; n++) begin
      wait_issue(4, seen);
      checks++;
      if (!seen || cmd !== exp_q[n]) begin
        errors++;
        $display("FAIL b2b_order %0d: seen=%b cmd=%0d, want %0d", n, seen, cmd, exp_q[n]);
      end
      if (n == 0) begin
        checks++;
        if (cmd_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL pop_no_free: ready=%b in pop cycle, want 0", cmd_in_ready);
        end
      end
      for (int w = 1; w <= 3; w++) begin
        tick();
        if (n == 0 && w == 1) begin
          checks++;
          if (cmd_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_pop: ready=%b, want 1", cmd_in_ready);
          end
        end
        checks++;
        if (done !== (w == 3) || cmd_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_done %0d w=%0d: done=%b cv=%b, want done=%b cv=0",
                   n, w, done, cmd_valid, w == 3);
        end
      end
      tick();
    end
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      if (cmd_valid || done) quiet++;
      tick();
    end
    checks++;
    if (quiet != 0) begin
      errors++;
      $display("FAIL b2b_drained: %0d active cycles after queue drained, want 0", quiet);
    end
  endtask

  task automatic test_busy_hold();
    bit seen;
    int extra;
    busy = 1'b0;
    push_one(3'd3);
    wait_issue(4, seen);
    checks++;
    if (!seen || cmd !== 3'd3) begin
      errors++;
      $display("FAIL busy_issue: seen=%b cmd=%0d, want 1 3", seen, cmd);
    end
    busy = 1'b1;
    extra = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (done || cmd_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_hold: %0d cycles with done/cmd_valid while busy, want 0", extra);
    end
    busy = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL busy_release_done: done=%b, want 1", done);
    end
    tick();
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || cmd_valid) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_after: %0d extra done/cmd_valid cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_mid_load();
    bit seen;
    int extra;
    busy = 1'b1;
    push_one(3'd1);
    push_one(3'd5);
    push_one(3'd6);
    busy = 1'b0;
    wait_issue(4, seen);
    for (int k = 1; k <= 30; k++) tick();
    checks++;
    if (!seen || datain !== 8'd87 || img_addr !== 6'd30) begin
      errors++;
      $display("FAIL mid_load_pos: seen=%b din=%0d addr=%0d, want 1 87 30", seen, datain, img_addr);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({cmd_in_ready, cmd_valid, cmd, datain, img_rd, img_addr, done} !==
        {1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: rdy=%b cv=%b cmd=%0d din=%0d rd=%b addr=%0d done=%b",
               cmd_in_ready, cmd_valid, cmd, datain, img_rd, img_addr, done);
    end
    tick(); tick();
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || cmd_valid || img_rd) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_discard: %0d active cycles after release, want 0", extra);
    end
    push_one(3'd2);
    wait_issue(4, seen);
    checks++;
    if (!seen || cmd !== 3'd2) begin
      errors++;
      $display("FAIL fresh_after_reset: seen=%b cmd=%0d, want 1 2", seen, cmd);
    end
    tick(); tick(); tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL fresh_done: done=%b, want 1", done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_busy_hold();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
